// File: rtl/cpu_defs.sv
// Shared definitions for the fetch sequencer: word width, NOP encoding and
// fetch FSM state encodings.
package cpu_defs;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] INST_NOP = 32'h0000_0000;

  typedef logic [1:0] fstate_t;

  localparam fstate_t FS_BOOT = 2'd0;
  localparam fstate_t FS_RUN  = 2'd1;
  localparam fstate_t FS_HALT = 2'd2;

endpackage

// File: rtl/fetch_ctrl_pc_next.sv
// Combinational next-PC / priority / fault-check unit for the fetch sequencer.
//
// state   | meaning
// BOOT    | one cycle after reset, PC = RESET_PC, nothing fetched
// RUN     | fetching; halt_req > redirect > stall > sequential
// HALT    | frozen until reset (halt request or fetch fault)
module pc_next
  import cpu_defs::*;
#(
  parameter int ROM_WORDS = 64
) (
  input  logic [1:0]        state,
  input  logic [WORD_W-1:0] pc,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic [1:0]        state_nxt,
  output logic [WORD_W-1:0] pc_nxt,
  output logic              capture,
  output logic              clr_valid,
  output logic              set_fault,
  output logic              stall_cyc
);

  localparam logic [WORD_W-1:0] LIMIT = 32'(ROM_WORDS * 4);

  logic [WORD_W-1:0] pc_inc;
  logic              redir_bad;
  logic              seq_bad;

  assign pc_inc    = pc + 32'd4;
  assign redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= LIMIT);
  assign seq_bad   = (pc_inc >= LIMIT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    capture   = 1'b0;
    clr_valid = 1'b0;
    set_fault = 1'b0;
    stall_cyc = 1'b0;
    case (state)
      FS_BOOT: begin
        state_nxt = FS_RUN;
        clr_valid = 1'b1;
      end
      FS_RUN: begin
        if (halt_req) begin
          state_nxt = FS_HALT;
          clr_valid = 1'b1;
        end else if (redirect) begin
          clr_valid = 1'b1;
          if (redir_bad) begin
            set_fault = 1'b1;
            state_nxt = FS_HALT;
          end else begin
            pc_nxt = redirect_pc;
          end
        end else if (stall) begin
          stall_cyc = 1'b1;
        end else begin
          // the last ROM word is still captured; only the step past it faults
          capture = 1'b1;
          if (seq_bad) begin
            set_fault = 1'b1;
            state_nxt = FS_HALT;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      default: begin
        state_nxt = FS_HALT;
        clr_valid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, ROM address, IF/ID register, fault/halt.
// Optional FETCH_PERF_EN adds fetch and stall cycle counters.
module fetch_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_a,
  input  logic [31:0] rom_inst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        fault,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
`endif
);

  logic [1:0]  state_q;
  logic [1:0]  state_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic        capture;
  logic        clr_valid;
  logic        set_fault;
  logic        stall_cyc;

  pc_next #(
    .ROM_WORDS(ROM_WORDS)
  ) u_pc_next (
    .state      (state_q),
    .pc         (pc_q),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt_req   (halt_req),
    .state_nxt  (state_nxt),
    .pc_nxt     (pc_nxt),
    .capture    (capture),
    .clr_valid  (clr_valid),
    .set_fault  (set_fault),
    .stall_cyc  (stall_cyc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FS_BOOT;
      pc_q     <= RESET_PC;
      if_valid <= 1'b0;
      if_inst  <= INST_NOP;
      if_pc    <= 32'h0;
      fault    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      if (capture) begin
        if_valid <= 1'b1;
        if_inst  <= rom_inst;
        if_pc    <= pc_q;
      end else if (clr_valid) begin
        if_valid <= 1'b0;
      end
      if (set_fault) fault <= 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= 32'h0;
      perf_stall <= 32'h0;
    end else begin
      if (capture)   perf_fetch <= perf_fetch + 32'd1;
      if (stall_cyc) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  assign rom_a  = pc_q;
  assign if_pc4 = if_pc + 32'd4;
  assign halted = (state_q == FS_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: cycle model feeding a scoreboard of
// expected IF/ID captures; optional FETCH_PERF_EN counters checked too.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] LIMIT  = 32'h0000_0100;
  localparam logic [1:0]  M_BOOT = 2'd0;
  localparam logic [1:0]  M_RUN  = 2'd1;
  localparam logic [1:0]  M_HALT = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_a;
  logic [31:0] rom_inst;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fault;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  // ROM word k holds 0x1000_0000 + k
  assign rom_inst = 32'h1000_0000 + {2'b00, rom_a[31:2]};

  fetch_ctrl #(.RESET_PC(RST_PC), .ROM_WORDS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_a      (rom_a),
    .rom_inst   (rom_inst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt_req   (halt_req),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4),
    .fault      (fault),
    .halted     (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  logic [1:0]  ms;
  logic [31:0] mpc;
  logic        mvalid;
  logic        mfault;
  logic [31:0] lpc;
  logic [31:0] linst;
  logic [31:0] mperf_f;
  logic [31:0] mperf_s;
  logic [63:0] sb_q[$];

  task automatic tally(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r_rst, input logic h, input logic r,
                     input logic [31:0] rpc, input logic s);
    logic        cap;
    logic        held;
    logic [31:0] nxt;
    logic [63:0] e;
    @(negedge clk);
    rst = r_rst; halt_req = h; redirect = r; redirect_pc = rpc; stall = s;
    @(posedge clk);
    cap  = 1'b0;
    held = 1'b0;
    if (r_rst) begin
      ms = M_BOOT; mpc = RST_PC; mvalid = 1'b0; mfault = 1'b0;
      lpc = 32'h0; linst = 32'h0; mperf_f = 32'h0; mperf_s = 32'h0;
      held = 1'b1;
    end else begin
      case (ms)
        M_BOOT: begin ms = M_RUN; mvalid = 1'b0; end
        M_RUN: begin
          if (h) begin
            ms = M_HALT; mvalid = 1'b0;
          end else if (r) begin
            mvalid = 1'b0;
            if (rpc[1:0] != 2'b00 || rpc >= LIMIT) begin
              mfault = 1'b1; ms = M_HALT;
            end else mpc = rpc;
          end else if (s) begin
            held = 1'b1;
            mperf_s = mperf_s + 1;
          end else begin
            sb_q.push_back({mpc, 32'h1000_0000 + (mpc >> 2)});
            cap = 1'b1;
            mvalid = 1'b1;
            mperf_f = mperf_f + 1;
            nxt = mpc + 32'd4;
            if (nxt >= LIMIT) begin
              mfault = 1'b1; ms = M_HALT;
            end else mpc = nxt;
          end
        end
        default: mvalid = 1'b0;
      endcase
    end
    #1;
    tally("rom_a", rom_a, mpc);
    tally("if_valid", {31'b0, if_valid}, {31'b0, mvalid});
    tally("fault", {31'b0, fault}, {31'b0, mfault});
    tally("halted", {31'b0, halted}, {31'b0, ms == M_HALT});
`ifdef FETCH_PERF_EN
    tally("perf_fetch", perf_fetch, mperf_f);
    tally("perf_stall", perf_stall, mperf_s);
`endif
    if (cap) begin
      if (sb_q.size() == 0) tally("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        lpc = e[63:32];
        linst = e[31:0];
        tally("if_pc", if_pc, lpc);
        tally("if_inst", if_inst, linst);
      end
    end else if (held) begin
      tally("if_pc_hold", if_pc, lpc);
      tally("if_inst_hold", if_inst, linst);
    end
    if (cap || held) tally("if_pc4", if_pc4, lpc + 32'd4);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic reset_cycles(input int n, input logic h, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b1, h, r, 32'h40, 1'b0);
  endtask

  initial begin
    ms = M_BOOT; mpc = RST_PC; mvalid = 1'b0; mfault = 1'b0;
    lpc = 32'h0; linst = 32'h0; mperf_f = 32'h0; mperf_s = 32'h0;

    // reset release: BOOT then 0, 4, 8
    reset_cycles(2, 1'b0, 1'b0);
    idle(4);
    // stall three cycles at if_pc = 8, then 12
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(2);
    // redirect while stalled
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h20, 1'b1);
    idle(3);
    // misaligned redirect faults
    cyc(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
    idle(2);

    // reset overrides redirect and halt_req; out-of-range redirect faults
    reset_cycles(1, 1'b1, 1'b1);
    idle(3);
    cyc(1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
    idle(2);

    // sequential run off the end of the ROM
    reset_cycles(1, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 32'hF0, 1'b0);
    idle(6);

    // halt_req held through reset: BOOT, then HALT on first RUN cycle
    reset_cycles(2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);

    // halt_req beats a simultaneous redirect
    reset_cycles(1, 1'b0, 1'b0);
    idle(3);
    cyc(1'b0, 1'b1, 1'b1, 32'h40, 1'b0);
    idle(2);

    tally("sb_drain", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 32-bit CPU. Owns the program counter, drives the address of the combinational 64-word instruction ROM, and captures each returned word into a registered IF/ID stage with a valid flag. Handles stall from decode, squashing redirects (branch/jump) from execute, bounds/alignment faults, and a halt request.

## Interface
- `RESET_PC`, default `32'h00000000`: PC loaded on reset; must be word-aligned.
- `ROM_WORDS`, default `64`: number of ROM words; valid byte addresses are `0 .. ROM_WORDS*4-4`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rom_a` out 32: ROM byte address; combinational copy of the PC register.
- `rom_inst` in 32: ROM data for `rom_a`, valid in the same cycle.
- `stall` in 1: decode cannot accept; hold the IF/ID stage and the PC.
- `redirect` in 1: taken branch or jump this cycle.
- `redirect_pc` in 32: target byte address when `redirect`=1.
- `halt_req` in 1: stop fetching (syscall/break).
- `if_valid` out 1: `if_inst`/`if_pc` hold a real instruction.
- `if_inst` out 32: fetched instruction.
- `if_pc` out 32: address of `if_inst`.
- `if_pc4` out 32: `if_pc + 4`, combinational from `if_pc`.
- `fault` out 1: sticky; set on an illegal fetch address.
- `halted` out 1: high in the HALT state.

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on `rst`; PC=`RESET_PC`; `if_valid`=0. Always goes to RUN on the next cycle.
- RUN, with priority `halt_req` > `redirect` > `stall` > sequential:
  - `halt_req`: go to HALT; `if_valid`<=0; PC holds.
  - `redirect`: PC<=`redirect_pc`; `if_valid`<=0. The word fetched this cycle is squashed. There are no delay slots. `redirect` overrides `stall`.
  - `stall`: PC, `if_inst`, `if_pc` and `if_valid` all hold.
  - Sequential: `if_inst`<=`rom_inst`; `if_pc`<=PC; `if_valid`<=1; PC<=PC+4.
- Fault checks, in RUN only:
  - A redirect fault occurs when `redirect_pc[1:0]`!=0, or when `redirect_pc` >= `ROM_WORDS*4`.
  - A sequential fault occurs when PC+4 >= `ROM_WORDS*4`. The last word itself is still issued.
  - On a fault: `fault`<=1, go to HALT, `if_valid`<=0. The faulting address is not loaded into PC.
- HALT: `halted`=1; `if_valid`=0; PC frozen. HALT is left only via `rst`.
- Arithmetic: PC+4 is computed mod 2^32. The compare against `ROM_WORDS*4` is unsigned, 32-bit.

## Timing
- ROM path is combinational: `rom_a` → `rom_inst` within one cycle.
- Fetch-to-IF/ID latency is 1 cycle. The first valid instruction (`RESET_PC`) appears on `if_*` 2 cycles after `rst` deasserts (BOOT, then the first RUN capture).
- Redirect bubble:
  - Redirect in cycle N: target fetched in N+1.
  - `if_valid`=0 in N+1; the target appears in N+2.
- Stall: outputs are stable for every cycle `stall`=1. Capture resumes the cycle after `stall` falls, with no lost or duplicated instruction.
- Reset values: PC=`RESET_PC`, `rom_a`=`RESET_PC`, `if_valid`=0, `if_inst`=0, `if_pc`=0, `fault`=0, `halted`=0, state=BOOT.
- Reset mid-operation overrides everything, including `redirect` and `halt_req` in the same cycle.

## Configuration
- `FETCH_PERF_EN`
  - Defined:
    - Adds outputs `perf_fetch` (32) and `perf_stall` (32), both reset to 0.
    - `perf_fetch` increments on every cycle that sets `if_valid`<=1.
    - `perf_stall` increments on every RUN cycle with `stall`=1 and no `redirect`/`halt_req`.
    - Both wrap at 2^32.
  - Undefined: neither port nor counter exists; all other behaviour is identical.

## Structure
- Shared package/header `cpu_defs`: state encodings `FS_BOOT`, `FS_RUN`, `FS_HALT`; `WORD_W`=32; `INST_NOP`=`32'h00000000`.
- One sub-module, `pc_next`: a combinational next-PC/priority/fault-check unit. The top holds the state, PC, IF/ID registers and counters.

## Test plan
- Reset release with the ROM holding word k = `32'h1000_0000+k` → `if_pc` = 0, 4, 8 with `if_inst` = `32'h10000000`, `32'h10000001`, `32'h10000002` on consecutive cycles, starting 2 cycles after reset.
- `stall` high for 3 cycles at `if_pc`=8 → `if_*` frozen for 3 cycles, then `if_pc`=12. With `FETCH_PERF_EN`, `perf_stall`=3.
- `redirect` with `redirect_pc`=`32'h20` while stalled → next cycle `rom_a`=`32'h20`, `if_valid`=0; following cycle `if_pc`=`32'h20`.
- `redirect_pc`=`32'h22`, and separately `redirect_pc`=`32'h100` → `fault`=1 and `halted`=1 next cycle, `if_valid`=0, `rom_a` unchanged.
- Sequential run to the end → `if_pc`=`32'hFC` is issued valid, then `fault`=1 and `halted`=1. `rst` with `halt_req` held → BOOT, `fault`=0, then immediate HALT in the first RUN cycle.
